pin_entry_checker: RTL and testbench
====================================

# pin_entry_checker

Keypad PIN entry stage that sits directly upstream of the security alarm logic: collects BCD keypad digits, compares the completed entry against a stored code, and drives the `PIN` level the alarm stage combines with `KC` and `LOCK`. Enforces a limited number of wrong attempts followed by a timed lockout, abandons stale entries after an inactivity timeout, and allows the stored code to be reloaded while idle.

## Interface
Parameters:
- `DIGITS`, 4: digits per code.
- `MAX_TRIES`, 3: consecutive wrong entries before lockout (≥1).
- `CODE`, 16'h1234: reset value of the stored code, BCD, most significant digit first; width 4*DIGITS.
- `GRANT_CYCLES`, 8: cycles `PIN` stays high after a correct entry.
- `LOCKOUT_CYCLES`, 1000: lockout duration in cycles.
- `ENTRY_TIMEOUT`, 500: idle cycles before a partial entry is discarded.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `key_valid` in 1: one-cycle strobe, `key_digit` valid.
- `key_digit` in 4: BCD digit 0–9.
- `key_clear` in 1: strobe, discard the current entry.
- `key_enter` in 1: strobe, submit the current entry.
- `code_load` in 1: strobe, replace the stored code with `code_in`.
- `code_in` in 4*DIGITS: new code, BCD.
- `PIN` out 1: correct PIN presented, registered.
- `LOCKED` out 1: lockout active, registered.
- `tries_left` out $clog2(MAX_TRIES+1): remaining attempts, registered.
- `busy` out 1: entry in progress (state ENTRY).

## Operation
- Reset values: state IDLE, `PIN`=0, `LOCKED`=0, `busy`=0, `tries_left`=MAX_TRIES, digit buffer 0, digit count 0, stored code = `CODE`.
- Key event = `key_valid` with digit ≤9, or `key_clear`, or `key_enter`. A digit above 9 is dropped and is not an event.
- Same-cycle priority: `key_clear` > `key_enter` > `key_valid`.
- IDLE: a valid digit shifts into the buffer, count=1, go to ENTRY. `key_enter` or `key_clear` alone does nothing. `code_load` writes the stored code (IDLE only; ignored in all other states).
- ENTRY (`busy`=1):
  - A valid digit shifts left into the buffer while count<DIGITS; further digits are ignored and count saturates.
  - `key_clear`: go to IDLE, clear buffer and count, no attempt consumed.
  - `key_enter`: match iff count==DIGITS and buffer==code.
    - Match: go to GRANT, `tries_left`=MAX_TRIES.
    - Mismatch: decrement `tries_left`. If it reaches 0, go to LOCKOUT; otherwise go to IDLE.
    - Buffer and count are cleared in both cases.
  - ENTRY_TIMEOUT consecutive cycles without a key event: go to IDLE and clear, no attempt consumed. Each key event restarts the timer.
- GRANT: `PIN`=1. All keys are ignored. After GRANT_CYCLES, `PIN`=0 and go to IDLE.
- LOCKOUT: `LOCKED`=1. All keys are ignored. After LOCKOUT_CYCLES, `LOCKED`=0, `tries_left`=MAX_TRIES, go to IDLE.
- `rst_n` low in any state, including mid-entry, GRANT or LOCKOUT, returns to reset values on that edge. Reset also restores `CODE`, discarding any loaded code.

## Timing
- All outputs change only on the `clk` rising edge.
- `key_enter` sampled at edge N with a match: `PIN` is high after edge N for exactly GRANT_CYCLES cycles, falling at edge N+GRANT_CYCLES.
- Final wrong entry sampled at edge N: `LOCKED` is high after edge N for LOCKOUT_CYCLES cycles. A new digit is accepted from edge N+LOCKOUT_CYCLES+1.
- Timeout: the last key event is at edge N; IDLE is entered at edge N+ENTRY_TIMEOUT.
- `tries_left` updates at the same edge as the enter evaluation.
- A digit in the same cycle as `key_enter` is not included in the evaluated entry.

## Structure
- Shared package `pin_pkg`:
  - state enum {IDLE, ENTRY, GRANT, LOCKOUT};
  - `BCD_W`=4;
  - `bcd_valid` function (digit ≤9).
- Sub-module `cycle_timer`: loadable down-counter with load value and `done` flag. One instance is reused for timeout, grant and lockout, and is reloaded on every state change and key event. Width = $clog2 of the largest of the three cycle parameters.

## Test plan
- Reset, then keys 1,2,3,4, enter → `PIN`=1 for 8 cycles starting at the enter edge, `tries_left` stays 3.
- Keys 1,2,3,5, enter, three times → `tries_left` 2, then 1, then `LOCKED`=1 for 1000 cycles. A correct entry during lockout gives `PIN`=0. After lockout `tries_left`=3.
- Keys 1,2, `key_clear`, then 1,2,3,4, enter → `PIN`=1, `tries_left`=3. Keys 1,2,3, enter → counted as a mismatch, `tries_left`=2.
- Keys 1,2, then 500 idle cycles → `busy` falls at the 500th cycle. Keys 3,4, enter → mismatch.
- In IDLE, `code_load` with 16'h9876, then 9,8,7,6, enter → `PIN`=1. `code_load` during ENTRY → ignored, old code still matches.
- Digit 4'hA injected, `key_clear`+`key_enter` in the same cycle, and `rst_n` low during GRANT → digit dropped, clear wins, and `PIN`=0 with `CODE` restored after reset.

Source files
------------

// File: rtl/pin_pkg.sv
// Shared types and helpers for the keypad PIN entry stage.
package pin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        GRANT,
        LOCKOUT
    } state_t;

    localparam int BCD_W = 4;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return digit <= 4'd9;
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module cycle_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/pin_entry_checker.sv
// Keypad PIN collector/comparator with retry limit, lockout and entry timeout.
// state   | meaning
// IDLE    | waiting for first digit; stored code may be reloaded
// ENTRY   | collecting digits, inactivity timer running
// GRANT   | PIN high for GRANT_CYCLES
// LOCKOUT | LOCKED high for LOCKOUT_CYCLES, keys ignored
module pin_entry_checker
    import pin_pkg::*;
#(
    parameter int                 DIGITS         = 4,
    parameter int                 MAX_TRIES      = 3,
    parameter logic [4*DIGITS-1:0] CODE          = 16'h1234,
    parameter int                 GRANT_CYCLES   = 8,
    parameter int                 LOCKOUT_CYCLES = 1000,
    parameter int                 ENTRY_TIMEOUT  = 500
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               key_valid,
    input  logic [3:0]                         key_digit,
    input  logic                               key_clear,
    input  logic                               key_enter,
    input  logic                               code_load,
    input  logic [4*DIGITS-1:0]                code_in,
    output logic                               PIN,
    output logic                               LOCKED,
    output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
    output logic                               busy
);

    localparam int CODE_W  = BCD_W * DIGITS;
    localparam int CNT_W   = $clog2(DIGITS + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int MAX_GL  = (GRANT_CYCLES > LOCKOUT_CYCLES) ? GRANT_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_CYC = (MAX_GL > ENTRY_TIMEOUT) ? MAX_GL : ENTRY_TIMEOUT;
    localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Loaded with N-1 so the state holds for exactly N cycles.
    localparam logic [TMR_W-1:0] TMR_GRANT   = TMR_W'(GRANT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOCK    = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_TIMEOUT = TMR_W'(ENTRY_TIMEOUT - 1);

    state_t             state;
    logic [CODE_W-1:0]  digit_buf;
    logic [CNT_W-1:0]   digit_cnt;
    logic [CODE_W-1:0]  stored_code;

    logic               digit_ok;
    logic               key_event;
    logic               entry_match;
    logic               last_try;
    logic               timer_done;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_value;

    assign digit_ok    = key_valid && bcd_valid(key_digit);
    assign key_event   = digit_ok || key_clear || key_enter;
    assign entry_match = (digit_cnt == CNT_W'(DIGITS)) && (digit_buf == stored_code);
    assign last_try    = (tries_left == TRY_W'(1));

    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = TMR_TIMEOUT;
        case (state)
            IDLE: tmr_load = digit_ok && !key_clear && !key_enter;
            ENTRY: begin
                if (key_enter && !key_clear) begin
                    tmr_load = 1'b1;
                    if (entry_match) begin
                        tmr_value = TMR_GRANT;
                    end else if (last_try) begin
                        tmr_value = TMR_LOCK;
                    end
                end else begin
                    tmr_load = key_event || timer_done;
                end
            end
            GRANT, LOCKOUT: tmr_load = timer_done;
            default: tmr_load = 1'b0;
        endcase
    end

    cycle_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .done  (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            digit_buf   <= '0;
            digit_cnt   <= '0;
            stored_code <= CODE;
            tries_left  <= TRY_W'(MAX_TRIES);
            PIN         <= 1'b0;
            LOCKED      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (code_load) begin
                        stored_code <= code_in;
                    end
                    if (digit_ok && !key_clear && !key_enter) begin
                        digit_buf <= CODE_W'(key_digit);
                        digit_cnt <= CNT_W'(1);
                        state     <= ENTRY;
                        busy      <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (key_clear) begin
                        digit_buf <= '0;
                        digit_cnt <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end else if (key_enter) begin
                        digit_buf <= '0;
                        digit_cnt <= '0;
                        busy      <= 1'b0;
                        if (entry_match) begin
                            state      <= GRANT;
                            PIN        <= 1'b1;
                            tries_left <= TRY_W'(MAX_TRIES);
                        end else if (last_try) begin
                            state      <= LOCKOUT;
                            LOCKED     <= 1'b1;
                            tries_left <= tries_left - 1'b1;
                        end else begin
                            state      <= IDLE;
                            tries_left <= tries_left - 1'b1;
                        end
                    end else if (digit_ok) begin
                        // Digits beyond DIGITS are absorbed but still restart the timer.
                        if (digit_cnt < CNT_W'(DIGITS)) begin
                            digit_buf <= (digit_buf << BCD_W) | CODE_W'(key_digit);
                            digit_cnt <= digit_cnt + 1'b1;
                        end
                    end else if (timer_done) begin
                        digit_buf <= '0;
                        digit_cnt <= '0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                GRANT: begin
                    if (timer_done) begin
                        PIN   <= 1'b0;
                        state <= IDLE;
                    end
                end
                LOCKOUT: begin
                    if (timer_done) begin
                        LOCKED     <= 1'b0;
                        tries_left <= TRY_W'(MAX_TRIES);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry_checker.sv
// Self-checking bench for pin_entry_checker: entry vector table plus timing corner sequences.
module tb_pin_entry_checker;

    localparam int GRANT_CYCLES   = 8;
    localparam int LOCKOUT_CYCLES = 1000;
    localparam int ENTRY_TIMEOUT  = 500;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        key_clear;
    logic        key_enter;
    logic        code_load;
    logic [15:0] code_in;
    logic        PIN;
    logic        LOCKED;
    logic [1:0]  tries_left;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       pin;
        logic       locked;
        logic [1:0] tries;
        logic       busy;
    } exp_t;

    typedef struct {
        logic [23:0] dig;
        int          n;
        logic        pin;
        logic [1:0]  tries;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[6];

    pin_entry_checker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .key_enter  (key_enter),
        .code_load  (code_load),
        .code_in    (code_in),
        .PIN        (PIN),
        .LOCKED     (LOCKED),
        .tries_left (tries_left),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        tick();
        key_valid = 1'b0;
        key_digit = 4'd0;
    endtask

    task automatic press_code(input logic [23:0] dig, input int n);
        for (int i = n - 1; i >= 0; i--) press(dig[4*i +: 4]);
    endtask

    // Expected outcome is queued when enter is driven and retired once the edge has passed.
    task automatic submit(input string name, input logic pin, input logic locked, input logic [1:0] tries);
        exp_t e;
        e.name   = name;
        e.pin    = pin;
        e.locked = locked;
        e.tries  = tries;
        e.busy   = 1'b0;
        sbq.push_back(e);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        if (sbq.size() == 0) begin
            chk({name, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk({e.name, ".pin"},    32'(PIN),        32'(e.pin));
            chk({e.name, ".locked"}, 32'(LOCKED),     32'(e.locked));
            chk({e.name, ".tries"},  32'(tries_left), 32'(e.tries));
            chk({e.name, ".busy"},   32'(busy),       32'(e.busy));
        end
    endtask

    initial begin
        int hi;
        int lock_cnt;
        int guard;
        logic pin_seen;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
        key_clear = 1'b0;
        key_enter = 1'b0;
        code_load = 1'b0;
        code_in   = 16'h0000;
        idle(2);
        rst_n = 1'b1;

        chk("rst.pin",    32'(PIN),        32'd0);
        chk("rst.locked", 32'(LOCKED),     32'd0);
        chk("rst.tries",  32'(tries_left), 32'd3);
        chk("rst.busy",   32'(busy),       32'd0);

        vecs[0] = '{24'h001234, 4, 1'b1, 2'd3};
        vecs[1] = '{24'h001235, 4, 1'b0, 2'd2};
        vecs[2] = '{24'h000123, 3, 1'b0, 2'd1};
        vecs[3] = '{24'h012345, 5, 1'b1, 2'd3};
        vecs[4] = '{24'h000000, 4, 1'b0, 2'd2};
        vecs[5] = '{24'h001234, 4, 1'b1, 2'd3};
        for (int v = 0; v < 6; v++) begin
            press_code(vecs[v].dig, vecs[v].n);
            chk($sformatf("vec%0d.busy_in", v), 32'(busy), 32'd1);
            submit($sformatf("vec%0d", v), vecs[v].pin, 1'b0, vecs[v].tries);
            if (vecs[v].pin) idle(GRANT_CYCLES);
        end

        // Grant pulse width
        press_code(24'h001234, 4);
        submit("grant", 1'b1, 1'b0, 2'd3);
        hi = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (PIN) hi++;
        end
        chk("grant.len", 32'(hi), 32'(GRANT_CYCLES));

        // Three wrong entries, then lockout with a correct code attempted inside it
        press_code(24'h001235, 4);
        submit("wrong1", 1'b0, 1'b0, 2'd2);
        press_code(24'h001235, 4);
        submit("wrong2", 1'b0, 1'b0, 2'd1);
        press_code(24'h001235, 4);
        submit("wrong3", 1'b0, 1'b1, 2'd0);
        lock_cnt = 1;
        pin_seen = 1'b0;
        guard    = 0;
        while (LOCKED && guard < LOCKOUT_CYCLES + 100) begin
            if (guard >= 10 && guard <= 13) begin
                key_valid = 1'b1;
                key_digit = 4'(guard - 9);
            end
            if (guard == 14) key_enter = 1'b1;
            tick();
            key_valid = 1'b0;
            key_enter = 1'b0;
            key_digit = 4'd0;
            if (LOCKED) lock_cnt++;
            if (PIN) pin_seen = 1'b1;
            guard++;
        end
        chk("lock.len",    32'(lock_cnt),   32'(LOCKOUT_CYCLES));
        chk("lock.pin",    32'(pin_seen),   32'd0);
        chk("lock.tries",  32'(tries_left), 32'd3);
        chk("lock.busy",   32'(busy),       32'd0);
        press(4'd1);
        chk("lock.first_digit", 32'(busy), 32'd1);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("lock.clear", 32'(busy), 32'd0);

        // Clear mid-entry, then short entry counts as a mismatch
        press_code(24'h000012, 2);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clr.busy",  32'(busy),       32'd0);
        chk("clr.tries", 32'(tries_left), 32'd3);
        press_code(24'h001234, 4);
        submit("clr.match", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);
        press_code(24'h000123, 3);
        submit("clr.short", 1'b0, 1'b0, 2'd2);
        press_code(24'h001234, 4);
        submit("clr.restore", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);

        // Inactivity timeout discards the partial entry
        press_code(24'h000012, 2);
        idle(ENTRY_TIMEOUT - 1);
        chk("to.before", 32'(busy), 32'd1);
        tick();
        chk("to.after", 32'(busy), 32'd0);
        press_code(24'h000034, 2);
        submit("to.stale", 1'b0, 1'b0, 2'd2);
        press(4'd1);
        idle(300);
        press(4'd2);
        idle(300);
        chk("to.restart", 32'(busy), 32'd1);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        press_code(24'h001234, 4);
        submit("to.restore", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);

        // Code reload in IDLE is taken, in ENTRY it is ignored
        code_in   = 16'h9876;
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
        press_code(24'h009876, 4);
        submit("load.idle", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);
        press(4'd9);
        code_in   = 16'h1111;
        code_load = 1'b1;
        tick();
        code_load = 1'b0;
        press_code(24'h000876, 3);
        submit("load.entry", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);

        // Non-BCD digit dropped, clear beats enter, reset during GRANT
        press(4'hA);
        chk("bad_digit.idle", 32'(busy), 32'd0);
        press_code(24'h09A876, 5);
        submit("bad_digit.entry", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);
        press_code(24'h009876, 4);
        key_clear = 1'b1;
        key_enter = 1'b1;
        tick();
        key_clear = 1'b0;
        key_enter = 1'b0;
        chk("clr_enter.busy",  32'(busy),       32'd0);
        chk("clr_enter.pin",   32'(PIN),        32'd0);
        chk("clr_enter.tries", 32'(tries_left), 32'd3);
        press_code(24'h009876, 4);
        submit("rst_grant.pre", 1'b1, 1'b0, 2'd3);
        idle(2);
        rst_n = 1'b0;
        tick();
        chk("rst_grant.pin",   32'(PIN),        32'd0);
        chk("rst_grant.busy",  32'(busy),       32'd0);
        chk("rst_grant.tries", 32'(tries_left), 32'd3);
        rst_n = 1'b1;
        press_code(24'h001234, 4);
        submit("rst_grant.code", 1'b1, 1'b0, 2'd3);
        idle(GRANT_CYCLES);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
